// File: rtl/fir_mca_accumulator.sv
// ---------------------------------------------------------------------------
// FIR_pkg / fir_mca_accumulator
//
// Purpose
//   Multi-cycle adder that sits right after the FIR lookup stage. When a
//   request is accepted it captures all N_TERMS signed partial products and
//   reduces them to a single signed sum, adding ADDS_PER_CYCLE terms per
//   clock. This trades throughput for a much smaller adder tree in the
//   downsampled estimator datapath.
//
// Ports
//   clk_i      : clock, rising edge
//   rst_ni     : asynchronous active-low reset
//   start_i    : request a new sum (only honoured while idle)
//   terms_i    : N_TERMS partial products, term j at [j*IN_W +: IN_W]
//   busy_o     : high while the adder is working through the terms
//   valid_o    : one-cycle pulse, result_o carries a freshly finished sum
//   result_o   : signed sum of all terms, held until the next sum completes
//   overrun_o  : one-cycle pulse, a start_i arrived while busy and was dropped
// ---------------------------------------------------------------------------

package FIR_pkg;
    typedef enum logic {
        MCA_IDLE,
        MCA_ADDING
    } state_mca_e;
endpackage

module fir_mca_accumulator
    import FIR_pkg::*;
#(
    parameter  int N_TERMS        = 64,
    parameter  int IN_W           = 16,
    parameter  int ADDS_PER_CYCLE = 8,
    localparam int OUT_W          = IN_W + $clog2(N_TERMS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [N_TERMS*IN_W-1:0]  terms_i,
    output logic                     busy_o,
    output logic                     valid_o,
    output logic [OUT_W-1:0]         result_o,
    output logic                     overrun_o
);

    localparam int N_CYC     = (N_TERMS + ADDS_PER_CYCLE - 1) / ADDS_PER_CYCLE;
    // The operand register is padded with zero terms up to a whole number of
    // chunks, so the last chunk needs no special casing for missing terms.
    localparam int PAD_TERMS = N_CYC * ADDS_PER_CYCLE;
    localparam int CNT_W     = (N_CYC > 1) ? $clog2(N_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CYC - 1);

    state_mca_e                 state_q;
    state_mca_e                 state_d;
    logic                       accept;
    logic                       finish;
    logic [CNT_W-1:0]           cnt_q;
    logic [PAD_TERMS*IN_W-1:0]  operand_q;
    logic signed [OUT_W-1:0]    acc_q;
    logic signed [OUT_W-1:0]    chunk_sum;
    logic signed [OUT_W-1:0]    next_acc;
    logic signed [IN_W-1:0]     term;
    logic [OUT_W-1:0]           result_q;
    logic                       valid_q;
    logic                       overrun_q;

    // State register for the idle/adding controller.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= MCA_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A request is only taken while idle; the adding phase
    // always runs the full N_CYC chunks and then drops straight back to idle,
    // so a start in the valid_o cycle is accepted immediately.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            MCA_IDLE: begin
                if (start_i) begin
                    state_d = MCA_ADDING;
                    accept  = 1'b1;
                end
            end
            MCA_ADDING: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = MCA_IDLE;
                    finish  = 1'b1;
                end
            end
            default: begin
                state_d = MCA_IDLE;
            end
        endcase
    end

    // Sum of the chunk selected by the counter. Each term is sign-extended to
    // the full result width before adding, so no intermediate can overflow.
    always_comb begin
        chunk_sum = '0;
        term      = '0;
        for (int i = 0; i < ADDS_PER_CYCLE; i++) begin
            term      = operand_q[(int'(cnt_q) * ADDS_PER_CYCLE + i) * IN_W +: IN_W];
            chunk_sum = chunk_sum + OUT_W'(term);
        end
        next_acc = acc_q + chunk_sum;
    end

    // Datapath: capture operands on acceptance, accumulate one chunk per
    // adding cycle, and publish the final sum with a single-cycle valid pulse.
    // Overrun flags a start that arrived while busy; it never disturbs the
    // sum in progress.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= finish;
            overrun_q <= (state_q == MCA_ADDING) && start_i;
            if (accept) begin
                operand_q <= (PAD_TERMS*IN_W)'(terms_i);
                acc_q     <= '0;
                cnt_q     <= '0;
            end else if (state_q == MCA_ADDING) begin
                acc_q <= next_acc;
                if (finish) begin
                    result_q <= next_acc;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign busy_o    = (state_q == MCA_ADDING);
    assign valid_o   = valid_q;
    assign result_o  = result_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_fir_mca_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fir_mca_accumulator
//
// Purpose
//   Self-checking bench for fir_mca_accumulator. Two instances are used: the
//   default 64-term / 8-per-cycle build and a 10-term / 4-per-cycle build whose
//   last chunk is only partly filled. Expected sums come from a plain integer
//   sum over the terms the bench generated.
// ---------------------------------------------------------------------------

module tb_fir_mca_accumulator;

    localparam int NA    = 64;
    localparam int NB    = 10;
    localparam int IN_W  = 16;
    localparam int OWA   = IN_W + $clog2(NA);
    localparam int OWB   = IN_W + $clog2(NB);
    localparam int LAT_A = 9;
    localparam int LAT_B = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 start_a;
    logic [NA*IN_W-1:0]   terms_a;
    logic                 busy_a;
    logic                 valid_a;
    logic [OWA-1:0]       result_a;
    logic                 overrun_a;
    logic                 start_b;
    logic [NB*IN_W-1:0]   terms_b;
    logic                 busy_b;
    logic                 valid_b;
    logic [OWB-1:0]       result_b;
    logic                 overrun_b;

    int model_a [NA];
    int model_b [NB];
    int compared;
    int mismatched;

    fir_mca_accumulator #(.N_TERMS(NA), .IN_W(IN_W), .ADDS_PER_CYCLE(8)) dut_a (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start_a),
        .terms_i   (terms_a),
        .busy_o    (busy_a),
        .valid_o   (valid_a),
        .result_o  (result_a),
        .overrun_o (overrun_a)
    );

    fir_mca_accumulator #(.N_TERMS(NB), .IN_W(IN_W), .ADDS_PER_CYCLE(4)) dut_b (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start_b),
        .terms_i   (terms_b),
        .busy_o    (busy_b),
        .valid_o   (valid_b),
        .result_o  (result_b),
        .overrun_o (overrun_b)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and on disagreement counts a failure and
    // reports the tag with observed and expected values.
    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Fill both term models by a rule (0: all +1, 1: all most-negative,
    // 2: random, 3: ramp j-5) and drive them onto the term buses.
    task automatic applyStimulus(input int mode);
        for (int j = 0; j < NA; j++) begin
            case (mode)
                0:       model_a[j] = 1;
                1:       model_a[j] = -32768;
                3:       model_a[j] = j - 5;
                default: model_a[j] = int'($urandom_range(0, 65535)) - 32768;
            endcase
            terms_a[j*IN_W +: IN_W] = model_a[j][IN_W-1:0];
        end
        for (int j = 0; j < NB; j++) begin
            case (mode)
                0:       model_b[j] = 1;
                1:       model_b[j] = -32768;
                3:       model_b[j] = j - 5;
                default: model_b[j] = int'($urandom_range(0, 65535)) - 32768;
            endcase
            terms_b[j*IN_W +: IN_W] = model_b[j][IN_W-1:0];
        end
    endtask

    function automatic longint refSumA();
        longint s = 0;
        for (int j = 0; j < NA; j++) s += longint'(model_a[j]);
        return s;
    endfunction

    function automatic longint refSumB();
        longint s = 0;
        for (int j = 0; j < NB; j++) s += longint'(model_b[j]);
        return s;
    endfunction

    // Issue one request on instance A (called at a negedge while idle), check
    // busy during the computation, latency, sum, and the one-cycle valid.
    // With scramble set the term bus is overwritten every busy cycle.
    task automatic runSumA(input string tag, input bit scramble);
        longint exp_sum = refSumA();
        int     cycles;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cycles  = 1;
        while (!valid_a && cycles < 40) begin
            checkOutput({tag, "_busy"}, busy_a, 1);
            if (scramble) begin
                for (int j = 0; j < NA; j++) terms_a[j*IN_W +: IN_W] = IN_W'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, LAT_A);
        checkOutput({tag, "_result"}, $signed(result_a), exp_sum);
        checkOutput({tag, "_idle_at_valid"}, busy_a, 0);
        @(negedge clk);
        checkOutput({tag, "_valid_drop"}, valid_a, 0);
        checkOutput({tag, "_result_hold"}, $signed(result_a), exp_sum);
    endtask

    // Same flow for the 10-term instance.
    task automatic runSumB(input string tag);
        longint exp_sum = refSumB();
        int     cycles;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cycles  = 1;
        while (!valid_b && cycles < 40) begin
            checkOutput({tag, "_busy"}, busy_b, 1);
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "_latency"}, cycles, LAT_B);
        checkOutput({tag, "_result"}, $signed(result_b), exp_sum);
        @(negedge clk);
        checkOutput({tag, "_valid_drop"}, valid_b, 0);
    endtask

    // Directed sequence: reset, fixed patterns, random sums, term changes
    // while busy, back-to-back requests with overruns, and a mid-sum reset.
    initial begin
        int     valid_seen;
        bit     prev_busy;
        longint held_sum;

        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        terms_a    = '0;
        terms_b    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_valid", valid_a, 0);
        checkOutput("rst_result", $signed(result_a), 0);
        checkOutput("rst_overrun", overrun_a, 0);
        checkOutput("rst_result_b", $signed(result_b), 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_busy", busy_a, 0);

        $display("[TB] all-ones and most-negative patterns");
        applyStimulus(0);
        runSumA("ones", 1'b0);
        checkOutput("ones_const", $signed(result_a), 64);
        applyStimulus(1);
        runSumA("neg_full", 1'b0);
        checkOutput("neg_full_const", $signed(result_a), -2097152);

        $display("[TB] random sums");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(2);
            runSumA("rand", 1'b0);
        end
        applyStimulus(2);
        runSumA("scramble", 1'b1);

        $display("[TB] partial last chunk instance");
        applyStimulus(3);
        runSumB("ramp");
        checkOutput("ramp_const", $signed(result_b), -5);
        for (int r = 0; r < 3; r++) begin
            applyStimulus(2);
            runSumB("rand_b");
        end

        // start held high: a sum every LAT_A cycles, and an overrun in each
        // cycle that follows a busy cycle.
        $display("[TB] start held high");
        applyStimulus(0);
        held_sum   = refSumA();
        start_a    = 1'b1;
        prev_busy  = 1'b0;
        valid_seen = 0;
        for (int c = 1; c <= 3 * LAT_A; c++) begin
            @(negedge clk);
            checkOutput("held_busy", busy_a, (c % LAT_A) != 0);
            checkOutput("held_valid", valid_a, (c % LAT_A) == 0);
            checkOutput("held_overrun", overrun_a, prev_busy);
            if (valid_a) begin
                valid_seen++;
                checkOutput("held_result", $signed(result_a), held_sum);
            end
            prev_busy = ((c % LAT_A) != 0);
        end
        start_a = 1'b0;
        checkOutput("held_count", valid_seen, 3);
        @(negedge clk);
        checkOutput("held_overrun_clear", overrun_a, 0);

        // Reset in the 4th adding cycle abandons the sum.
        $display("[TB] reset during a sum");
        applyStimulus(2);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", busy_a, 0);
        checkOutput("midrst_valid", valid_a, 0);
        checkOutput("midrst_result", $signed(result_a), 0);
        checkOutput("midrst_overrun", overrun_a, 0);
        repeat (2) @(negedge clk);
        rst_n      = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (valid_a) valid_seen++;
        end
        checkOutput("midrst_no_valid", valid_seen, 0);
        checkOutput("midrst_result_kept", $signed(result_a), 0);
        applyStimulus(2);
        runSumA("post_rst", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
